// File: rtl/i2c_chan_arbiter.sv
// rtl/i2c_chan_arbiter.sv - I2C multi-channel bus-ownership arbiter with bus-free hold-off
module i2c_chan_arbiter #(
    parameter int N_CH                        = 4,
    parameter int WIDTH_CH_ID                 = 2,
    parameter int F_REF_T_BUF                 = 3,
    parameter int F_REF_SLOW_T_IDLE_MAX       = 2,
    parameter int WIDTH_F_REF_T_BUF           = 2,
    parameter int WIDTH_F_REF_SLOW_T_IDLE_MAX = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_f_ref,
    input  logic                   i_f_ref_slow,
    input  logic [N_CH-1:0]        i_ch_en,
    input  logic [N_CH-1:0]        i_scl,
    input  logic [N_CH-1:0]        i_sda,
    output logic [N_CH-1:0]        o_grant,
    output logic [WIDTH_CH_ID-1:0] o_grant_id,
    output logic                   o_busy,
    output logic                   o_start,
    output logic                   o_stop,
    output logic                   o_idle_timeout,
    output logic                   o_collision
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BUF   = 2'd2;

    localparam logic [N_CH-1:0] ONE = {{(N_CH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_F_REF_T_BUF-1:0] BUF_MAX =
        WIDTH_F_REF_T_BUF'(F_REF_T_BUF);
    localparam logic [WIDTH_F_REF_SLOW_T_IDLE_MAX-1:0] IDLE_MAX =
        WIDTH_F_REF_SLOW_T_IDLE_MAX'(F_REF_SLOW_T_IDLE_MAX);

    logic [N_CH-1:0] s1_scl, s2_scl, d_scl;
    logic [N_CH-1:0] s1_sda, s2_sda, d_sda;
    logic            ref_q, slow_q;

    logic [1:0]                             state, state_n;
    logic [WIDTH_CH_ID-1:0]                 owner_id, owner_n, first_id;
    logic [WIDTH_F_REF_SLOW_T_IDLE_MAX-1:0] idle_cnt, idle_cnt_n;
    logic [WIDTH_F_REF_T_BUF-1:0]           buf_cnt, buf_cnt_n;
    logic                                   start_n, stop_n, tmo_n, coll_n;

    logic [N_CH-1:0] start_det, stop_det, en_start, line_idle, owner_mask;
    logic            ref_tick, slow_tick;
    logic            owner_en, owner_start, owner_stop, owner_idle;
    logic            others_start, all_idle;

    // Sync and history flops preset to 1 so a released bus never decodes a false START.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_scl <= '1;
            s2_scl <= '1;
            d_scl  <= '1;
            s1_sda <= '1;
            s2_sda <= '1;
            d_sda  <= '1;
            ref_q  <= 1'b0;
            slow_q <= 1'b0;
        end else begin
            s1_scl <= i_scl;
            s2_scl <= s1_scl;
            d_scl  <= s2_scl;
            s1_sda <= i_sda;
            s2_sda <= s1_sda;
            d_sda  <= s2_sda;
            ref_q  <= i_f_ref;
            slow_q <= i_f_ref_slow;
        end
    end

    assign start_det  = s2_scl & d_scl & d_sda & ~s2_sda;
    assign stop_det   = s2_scl & d_scl & ~d_sda & s2_sda;
    assign en_start   = start_det & i_ch_en;
    assign line_idle  = s2_scl & s2_sda;
    assign ref_tick   = i_f_ref & ~ref_q;
    assign slow_tick  = i_f_ref_slow & ~slow_q;

    assign owner_mask   = ONE << owner_id;
    assign owner_en     = |(i_ch_en & owner_mask);
    assign owner_start  = |(start_det & owner_mask);
    assign owner_stop   = |(stop_det & owner_mask);
    assign owner_idle   = |(line_idle & owner_mask);
    assign others_start = |(en_start & ~owner_mask);
    assign all_idle     = &(line_idle | ~i_ch_en);

    always_comb begin
        first_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en_start[i]) begin
                first_id = WIDTH_CH_ID'(i);
            end
        end
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner_id;
        idle_cnt_n = idle_cnt;
        buf_cnt_n  = buf_cnt;
        start_n    = 1'b0;
        stop_n     = 1'b0;
        tmo_n      = 1'b0;
        coll_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|en_start) begin
                    state_n    = ST_GRANT;
                    owner_n    = first_id;
                    start_n    = 1'b1;
                    idle_cnt_n = '0;
                    buf_cnt_n  = '0;
                end
            end
            ST_GRANT: begin
                coll_n = others_start;
                // Release causes ranked: disable, STOP, timeout; owner START only if none fire.
                if (!owner_en) begin
                    state_n    = ST_BUF;
                    idle_cnt_n = '0;
                    buf_cnt_n  = '0;
                end else if (owner_stop) begin
                    state_n    = ST_BUF;
                    stop_n     = 1'b1;
                    idle_cnt_n = '0;
                    buf_cnt_n  = '0;
                end else if (idle_cnt == IDLE_MAX) begin
                    state_n    = ST_BUF;
                    tmo_n      = 1'b1;
                    idle_cnt_n = '0;
                    buf_cnt_n  = '0;
                end else if (owner_start) begin
                    start_n    = 1'b1;
                    idle_cnt_n = '0;
                end else if (!owner_idle) begin
                    idle_cnt_n = '0;
                end else if (slow_tick) begin
                    idle_cnt_n = idle_cnt + 1'b1;
                end
            end
            ST_BUF: begin
                coll_n = |en_start;
                if (buf_cnt == BUF_MAX) begin
                    state_n   = ST_IDLE;
                    buf_cnt_n = '0;
                end else if (!all_idle) begin
                    buf_cnt_n = '0;
                end else if (ref_tick) begin
                    buf_cnt_n = buf_cnt + 1'b1;
                end
            end
            default: begin
                state_n    = ST_IDLE;
                idle_cnt_n = '0;
                buf_cnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state          <= ST_IDLE;
            owner_id       <= '0;
            idle_cnt       <= '0;
            buf_cnt        <= '0;
            o_grant        <= '0;
            o_grant_id     <= '0;
            o_busy         <= 1'b0;
            o_start        <= 1'b0;
            o_stop         <= 1'b0;
            o_idle_timeout <= 1'b0;
            o_collision    <= 1'b0;
        end else begin
            state          <= state_n;
            owner_id       <= owner_n;
            idle_cnt       <= idle_cnt_n;
            buf_cnt        <= buf_cnt_n;
            o_grant        <= (state_n == ST_GRANT) ? (ONE << owner_n) : '0;
            o_grant_id     <= (state_n == ST_GRANT) ? owner_n : '0;
            o_busy         <= (state_n != ST_IDLE);
            o_start        <= start_n;
            o_stop         <= stop_n;
            o_idle_timeout <= tmo_n;
            o_collision    <= coll_n;
        end
    end

endmodule

// File: tb/tb_i2c_chan_arbiter.sv
// tb/tb_i2c_chan_arbiter.sv - scoreboard bench for i2c_chan_arbiter
module tb_i2c_chan_arbiter;

    localparam int T_BUF  = 3;
    localparam int T_IDLE = 2;
    localparam int K_START = 0, K_STOP = 1, K_TMO = 2, K_COLL = 3, K_DROP = 4, K_FREE = 5;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       f_ref = 1'b0;
    logic       f_ref_slow = 1'b0;
    logic [3:0] ch_en = 4'b1111;
    logic [3:0] scl = 4'b1111;
    logic [3:0] sda = 4'b1111;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy, start_p, stop_p, tmo_p, coll_p;

    i2c_chan_arbiter dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_f_ref        (f_ref),
        .i_f_ref_slow   (f_ref_slow),
        .i_ch_en        (ch_en),
        .i_scl          (scl),
        .i_sda          (sda),
        .o_grant        (grant),
        .o_grant_id     (grant_id),
        .o_busy         (busy),
        .o_start        (start_p),
        .o_stop         (stop_p),
        .o_idle_timeout (tmo_p),
        .o_collision    (coll_p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [3:0] g;
        logic [1:0] id;
        logic       busy;
        int         drv;
    } ev_t;

    ev_t  expq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;
    int   cur_drv = 0;

    // Abstract bus model: 0 idle, 1 granted, 2 bus-free hold-off.
    int   m_state = 0;
    int   m_owner = 0;
    int   m_idle_cnt = 0;
    int   m_buf_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int latency(input int kind);
        if (kind == K_DROP) return 1;
        if (kind == K_TMO || kind == K_FREE) return 2;
        return 3;
    endfunction

    task automatic push_ev(input int kind);
        ev_t e;
        e.kind = kind;
        e.g    = (m_state == 1) ? 4'(1 << m_owner) : 4'b0000;
        e.id   = (m_state == 1) ? 2'(m_owner) : 2'd0;
        e.busy = (m_state != 0);
        e.drv  = cur_drv;
        expq.push_back(e);
    endtask

    task automatic model_lines(input logic [3:0] st, input logic [3:0] sp);
        logic [3:0] est, idl;
        est = st & ch_en;
        idl = scl & sda;
        if (m_state == 0) begin
            if (est != 0) begin
                m_owner = lowest(est);
                m_state = 1;
                m_idle_cnt = 0;
                push_ev(K_START);
            end
        end else if (m_state == 1) begin
            if ((est & ~4'(1 << m_owner)) != 0) push_ev(K_COLL);
            if (sp[m_owner]) begin
                m_state = 2;
                m_buf_cnt = 0;
                push_ev(K_STOP);
            end else if (st[m_owner]) begin
                m_idle_cnt = 0;
                push_ev(K_START);
            end else if (!idl[m_owner]) begin
                m_idle_cnt = 0;
            end
        end else begin
            if (est != 0) push_ev(K_COLL);
            if ((idl | ~ch_en) != 4'b1111) m_buf_cnt = 0;
        end
    endtask

    task automatic set_lines(input logic [3:0] nscl, input logic [3:0] nsda);
        logic [3:0] st, sp;
        @(posedge clk); #1;
        cur_drv = cyc;
        st = scl & nscl & sda & ~nsda;
        sp = scl & nscl & ~sda & nsda;
        scl = nscl;
        sda = nsda;
        model_lines(st, sp);
        repeat (5) @(posedge clk);
    endtask

    task automatic set_ch(input int k, input logic c, input logic d);
        logic [3:0] ns, nd;
        ns = scl;
        nd = sda;
        ns[k] = c;
        nd[k] = d;
        set_lines(ns, nd);
    endtask

    task automatic do_start(input int k);
        if (!(scl[k] && sda[k])) begin
            set_ch(k, 1'b0, sda[k]);
            set_ch(k, 1'b0, 1'b1);
            set_ch(k, 1'b1, 1'b1);
        end
        set_ch(k, 1'b1, 1'b0);
    endtask

    task automatic do_stop(input int k);
        set_ch(k, 1'b0, sda[k]);
        set_ch(k, 1'b0, 1'b0);
        set_ch(k, 1'b1, 1'b0);
        set_ch(k, 1'b1, 1'b1);
    endtask

    task automatic do_bit(input int k, input logic b);
        set_ch(k, 1'b0, sda[k]);
        set_ch(k, 1'b0, b);
        set_ch(k, 1'b1, b);
    endtask

    task automatic do_park(input int k);
        set_ch(k, 1'b0, sda[k]);
        set_ch(k, 1'b0, 1'b1);
        set_ch(k, 1'b1, 1'b1);
    endtask

    task automatic set_en(input logic [3:0] nen);
        @(posedge clk); #1;
        cur_drv = cyc;
        ch_en = nen;
        if (m_state == 1 && !nen[m_owner]) begin
            m_state = 2;
            m_buf_cnt = 0;
            push_ev(K_DROP);
        end else if (m_state == 2 && (((scl & sda) | ~ch_en) != 4'b1111)) begin
            m_buf_cnt = 0;
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic ref_tick();
        @(posedge clk); #1;
        cur_drv = cyc;
        f_ref = 1'b1;
        if (m_state == 2 && (((scl & sda) | ~ch_en) == 4'b1111)) begin
            m_buf_cnt++;
            if (m_buf_cnt == T_BUF) begin
                m_state = 0;
                m_buf_cnt = 0;
                push_ev(K_FREE);
            end
        end
        repeat (2) @(posedge clk);
        #1 f_ref = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic slow_tick();
        @(posedge clk); #1;
        cur_drv = cyc;
        f_ref_slow = 1'b1;
        if (m_state == 1 && scl[m_owner] && sda[m_owner]) begin
            m_idle_cnt++;
            if (m_idle_cnt == T_IDLE) begin
                m_state = 2;
                m_buf_cnt = 0;
                push_ev(K_TMO);
            end
        end
        repeat (2) @(posedge clk);
        #1 f_ref_slow = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && expq.size() != 0; i++) @(posedge clk);
        if (expq.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected events never seen, head kind %0d", expq.size(), expq[0].kind);
            expq.delete();
        end
    endtask

    // Monitor: classifies each DUT output event and compares it with the scoreboard head.
    initial begin
        logic [3:0] prev_g;
        logic       prev_busy;
        int         kind;
        ev_t        e;
        prev_g = 4'b0000;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && rstn) begin
                kind = -1;
                if (start_p)                              kind = K_START;
                else if (stop_p)                          kind = K_STOP;
                else if (tmo_p)                           kind = K_TMO;
                else if (coll_p)                          kind = K_COLL;
                else if (prev_g != 0 && grant == 0)       kind = K_DROP;
                else if (prev_busy && !busy)              kind = K_FREE;
                else if (grant != prev_g)                 kind = 99;
                if (kind >= 0) begin
                    if (expq.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected event: got kind %0d grant %b, expected none (cycle %0d)", kind, grant, cyc);
                    end else begin
                        e = expq.pop_front();
                        chk("event kind", kind, e.kind);
                        chk("o_grant", grant, e.g);
                        chk("o_grant_id", grant_id, e.id);
                        chk("o_busy", busy, e.busy);
                        chk("event latency", cyc - e.drv, latency(e.kind));
                    end
                end
            end
            prev_g = grant;
            prev_busy = busy;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] nen;
        int r, k;

        repeat (3) @(posedge clk);
        #1;
        chk("reset o_grant", grant, 4'b0000);
        chk("reset o_grant_id", grant_id, 2'd0);
        chk("reset o_busy", busy, 1'b0);
        chk("reset pulses", {start_p, stop_p, tmo_p, coll_p}, 4'b0000);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        mon_en = 1'b1;

        // Basic grant on ch2 with a byte, STOP and bus-free hold-off.
        do_start(2);
        wait_drain();
        chk("basic o_grant", grant, 4'b0100);
        for (int i = 0; i < 8; i++) do_bit(2, 1'($urandom_range(0, 1)));
        do_stop(2);
        wait_drain();
        chk("basic busy in BUF", busy, 1'b1);
        repeat (3) ref_tick();
        wait_drain();
        chk("basic busy after t_buf", busy, 1'b0);

        // Simultaneous START on ch1 and ch3, then a collision from ch3.
        set_lines(scl, sda & ~4'b1010);
        wait_drain();
        chk("tie o_grant", grant, 4'b0010);
        do_start(3);
        do_stop(1);
        do_stop(3);
        repeat (3) ref_tick();
        wait_drain();

        // Idle timeout with lines parked high.
        do_start(0);
        do_park(0);
        slow_tick();
        slow_tick();
        wait_drain();
        chk("timeout o_grant", grant, 4'b0000);
        chk("timeout busy", busy, 1'b1);
        repeat (3) ref_tick();
        wait_drain();

        // BUF hold-off: a busy ch0 restarts the bus-free count; START in BUF collides.
        do_start(1);
        do_stop(1);
        ref_tick();
        ref_tick();
        set_ch(0, 1'b0, 1'b1);
        ref_tick();
        do_start(3);
        do_stop(3);
        set_ch(0, 1'b1, 1'b1);
        ref_tick();
        ref_tick();
        wait_drain();
        chk("holdoff busy", busy, 1'b1);
        ref_tick();
        wait_drain();
        chk("holdoff free", busy, 1'b0);

        // Owner disabled mid-transfer, then re-grant and asynchronous reset.
        do_start(2);
        do_bit(2, 1'b0);
        set_en(4'b1011);
        wait_drain();
        repeat (3) ref_tick();
        set_en(4'b1111);
        do_start(2);
        do_bit(2, 1'b1);
        set_ch(2, 1'b0, 1'b0);
        wait_drain();
        chk("pre-reset grant", grant, 4'b0100);
        mon_en = 1'b0;
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("async reset o_grant", grant, 4'b0000);
        chk("async reset o_busy", busy, 1'b0);
        chk("async reset o_grant_id", grant_id, 2'd0);
        m_state = 0;
        m_idle_cnt = 0;
        m_buf_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        do_park(2);
        repeat (20) @(posedge clk);
        chk("post-reset no grant", grant, 4'b0000);

        // Randomized traffic checked by the scoreboard.
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            k = $urandom_range(0, 3);
            if (r < 20) ref_tick();
            else if (r < 32) slow_tick();
            else if (r < 38) begin
                nen = ch_en;
                if (!nen[k]) nen[k] = 1'b1;
                else if ($urandom_range(0, 2) == 0) nen[k] = 1'b0;
                set_en(nen);
            end
            else if (r < 55) do_start(k);
            else if (r < 68) do_stop(k);
            else if (r < 90) do_bit(k, 1'($urandom_range(0, 1)));
            else do_park(k);
        end
        wait_drain();
        chk("final queue empty", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
